// File: rtl/rv32i_types.sv
`default_nettype none
// rv32i_types: shared widths and the i/d cache arbiter state encoding.
package rv32i_types;

  localparam int LINE_WIDTH = 256;
  localparam int ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/cache_arbiter.sv
`default_nettype none
// cache_arbiter: shares one cacheline adaptor between the i-cache and d-cache,
// one latched whole-line transaction at a time with alternating tie-break.
module cache_arbiter
  import rv32i_types::*;
#(
  parameter int s_line = LINE_WIDTH,
  parameter int s_addr = ADDR_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [s_addr-1:0] i_pmem_address,
  output logic [s_line-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [s_addr-1:0] d_pmem_address,
  input  logic [s_line-1:0] d_pmem_wdata,
  output logic [s_line-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              ca_read,
  output logic              ca_write,
  output logic [s_addr-1:0] ca_address,
  output logic [s_line-1:0] ca_wdata,
  input  logic [s_line-1:0] ca_rdata,
  input  logic              ca_resp
);

  arb_state_t        state, state_next;
  logic [s_addr-1:0] addr_r;
  logic [s_line-1:0] wdata_r;
  logic              read_r, write_r;
  logic              last_grant;   // 0 = I, 1 = D
  logic              i_req, d_req;
  logic              grant_i, grant_d, done_xfer;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    i_req       = i_pmem_read;
    d_req       = d_pmem_read | d_pmem_write;
    state_next  = state;
    grant_i     = 1'b0;
    grant_d     = 1'b0;
    done_xfer   = 1'b0;
    i_pmem_resp = 1'b0;
    d_pmem_resp = 1'b0;
    case (state)
      IDLE: begin
        // On a tie, D wins only if I was served last.
        if (d_req && (!i_req || !last_grant)) begin
          grant_d    = 1'b1;
          state_next = D_BUSY;
        end else if (i_req) begin
          grant_i    = 1'b1;
          state_next = I_BUSY;
        end
      end
      I_BUSY: begin
        if (ca_resp) begin
          i_pmem_resp = 1'b1;
          done_xfer   = 1'b1;
          state_next  = DONE;
        end
      end
      D_BUSY: begin
        if (ca_resp) begin
          d_pmem_resp = 1'b1;
          done_xfer   = 1'b1;
          state_next  = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r     <= '0;
      wdata_r    <= '0;
      read_r     <= 1'b0;
      write_r    <= 1'b0;
      last_grant <= 1'b1;
    end else if (grant_d) begin
      addr_r     <= d_pmem_address;
      wdata_r    <= d_pmem_wdata;
      // Simultaneous read+write is resolved as a writeback.
      write_r    <= d_pmem_write;
      read_r     <= d_pmem_read & ~d_pmem_write;
      last_grant <= 1'b1;
    end else if (grant_i) begin
      addr_r     <= i_pmem_address;
      read_r     <= 1'b1;
      write_r    <= 1'b0;
      last_grant <= 1'b0;
    end else if (done_xfer) begin
      read_r     <= 1'b0;
      write_r    <= 1'b0;
    end
  end

  assign ca_read      = read_r;
  assign ca_write     = write_r;
  assign ca_address   = addr_r;
  assign ca_wdata     = wdata_r;
  assign i_pmem_rdata = ca_rdata;
  assign d_pmem_rdata = ca_rdata;

endmodule
`default_nettype wire

// File: tb/tb_cache_arbiter.sv
`default_nettype none
// tb_cache_arbiter: scoreboard bench; expected line transactions are queued at
// request time and matched when the adaptor side sees a command.
module tb_cache_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_pmem_read;
  logic [31:0]  i_pmem_address;
  logic [255:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [31:0]  d_pmem_address;
  logic [255:0] d_pmem_wdata;
  logic [255:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         ca_read;
  logic         ca_write;
  logic [31:0]  ca_address;
  logic [255:0] ca_wdata;
  logic [255:0] ca_rdata;
  logic         ca_resp;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit           d;
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
  } txn_t;

  txn_t sb[$];

  always #5 clk = ~clk;

  cache_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .i_pmem_read   (i_pmem_read),
    .i_pmem_address(i_pmem_address),
    .i_pmem_rdata  (i_pmem_rdata),
    .i_pmem_resp   (i_pmem_resp),
    .d_pmem_read   (d_pmem_read),
    .d_pmem_write  (d_pmem_write),
    .d_pmem_address(d_pmem_address),
    .d_pmem_wdata  (d_pmem_wdata),
    .d_pmem_rdata  (d_pmem_rdata),
    .d_pmem_resp   (d_pmem_resp),
    .ca_read       (ca_read),
    .ca_write      (ca_write),
    .ca_address    (ca_address),
    .ca_wdata      (ca_wdata),
    .ca_rdata      (ca_rdata),
    .ca_resp       (ca_resp)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input bit d, input bit wr, input logic [31:0] a, input logic [255:0] w);
    txn_t t;
    t.d = d; t.wr = wr; t.addr = a; t.wdata = w;
    sb.push_back(t);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Acts as the adaptor: waits for a command, matches it against the queue,
  // holds for 'delay' cycles, then returns 'rd' with a one-cycle ca_resp.
  task automatic serve(input string tag, input int lat_exp, input int delay,
                       input logic [255:0] rd, input bit drop_mid, input bit hold);
    int   n;
    txn_t t;
    logic [31:0]  a0;
    logic [255:0] w0;
    n = 0;
    do begin
      step();
      n++;
    end while (!(ca_read || ca_write) && n < 20);
    if (!(ca_read || ca_write)) begin
      check({tag, "_timeout"}, 0, 1);
      return;
    end
    check({tag, "_lat"}, n, lat_exp);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
      return;
    end
    t = sb.pop_front();
    check({tag, "_cmd"}, {ca_read, ca_write}, {!t.wr, t.wr});
    check({tag, "_addr"}, ca_address, t.addr);
    if (t.wr) check({tag, "_wdata"}, ca_wdata, t.wdata);
    a0 = ca_address;
    w0 = ca_wdata;
    if (drop_mid) begin
      if (t.d) begin
        d_pmem_read = 1'b0; d_pmem_write = 1'b0;
        d_pmem_address = '1; d_pmem_wdata = '0;
      end else begin
        i_pmem_read = 1'b0; i_pmem_address = '1;
      end
    end
    for (int k = 1; k < delay; k++) begin
      step();
      check({tag, "_hold"}, {ca_read, ca_write, ca_address, i_pmem_resp, d_pmem_resp},
            {!t.wr, t.wr, a0, 2'b00});
      check({tag, "_hold_wdata"}, ca_wdata, w0);
    end
    ca_resp  = 1'b1;
    ca_rdata = rd;
    #1;
    check({tag, "_resp"}, {i_pmem_resp, d_pmem_resp}, t.d ? 2'b01 : 2'b10);
    check({tag, "_rdata"}, t.d ? d_pmem_rdata : i_pmem_rdata, rd);
    if (!hold) begin
      if (t.d) begin d_pmem_read = 1'b0; d_pmem_write = 1'b0; end
      else i_pmem_read = 1'b0;
    end
    step();
    ca_resp = 1'b0;
    #1;
    check({tag, "_done"}, {ca_read, ca_write, i_pmem_resp, d_pmem_resp}, 4'b0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    i_pmem_read = 1'b0; i_pmem_address = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    d_pmem_address = '0; d_pmem_wdata = '0;
    ca_rdata = '0; ca_resp = 1'b0;

    do_reset();
    #1;
    check("reset_out", {ca_read, ca_write, ca_address, ca_wdata, i_pmem_resp, d_pmem_resp}, '0);

    // Stray ca_resp while idle
    ca_resp = 1'b1;
    #1;
    check("stray_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
    step();
    ca_resp = 1'b0;
    check("stray_idle", {ca_read, ca_write}, 2'b00);

    // I-only read
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0060;
    push(0, 0, 32'h60, '0);
    serve("t1", 1, 5, {32{8'hA5}}, 0, 0);

    // D writeback, requester drops mid-transaction
    d_pmem_write = 1'b1; d_pmem_address = 32'h0000_1000;
    d_pmem_wdata = {8{32'h1234_5678}};
    push(1, 1, 32'h1000, {8{32'h1234_5678}});
    serve("t2", 2, 4, {8{32'h0BAD_F00D}}, 1, 0);

    // Illegal read+write resolves to a write
    d_pmem_read = 1'b1; d_pmem_write = 1'b1; d_pmem_address = 32'h0000_0300;
    d_pmem_wdata = {8{32'hDEAD_BEEF}};
    push(1, 1, 32'h300, {8{32'hDEAD_BEEF}});
    serve("t7", 2, 2, {8{32'h5555_AAAA}}, 0, 0);

    // Simultaneous requests after reset: I first, then D, then I again
    do_reset();
    i_pmem_read = 1'b1; i_pmem_address = 32'h40;
    d_pmem_read = 1'b1; d_pmem_address = 32'h80;
    push(0, 0, 32'h40, '0);
    push(1, 0, 32'h80, '0);
    serve("t3a", 1, 3, {8{32'h1111_1111}}, 0, 0);
    serve("t3b", 2, 3, {8{32'h2222_2222}}, 0, 0);
    i_pmem_read = 1'b1; i_pmem_address = 32'hC0;
    d_pmem_read = 1'b1; d_pmem_address = 32'hE0;
    push(0, 0, 32'hC0, '0);
    push(1, 0, 32'hE0, '0);
    serve("t3c", 2, 2, {8{32'h3333_3333}}, 0, 0);
    serve("t3d", 2, 2, {8{32'h4444_4444}}, 0, 0);

    // Reset while D_BUSY abandons the transaction
    do_reset();
    d_pmem_read = 1'b1; d_pmem_address = 32'h200;
    step();
    check("t4_busy", {ca_read, ca_write, ca_address}, {2'b10, 32'h200});
    d_pmem_read = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("t4_abort", {ca_read, ca_write, i_pmem_resp, d_pmem_resp}, 4'b0000);
    ca_resp = 1'b1;
    #1;
    check("t4_late_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
    step();
    ca_resp = 1'b0;
    check("t4_idle", {ca_read, ca_write}, 2'b00);

    // Back-to-back I requests held high
    i_pmem_read = 1'b1; i_pmem_address = 32'h100;
    push(0, 0, 32'h100, '0);
    push(0, 0, 32'h100, '0);
    serve("t5a", 1, 2, {8{32'h6666_6666}}, 0, 1);
    serve("t5b", 2, 2, {8{32'h7777_7777}}, 0, 0);

    check("sb_drained", sb.size(), 0);
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
